// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive-side 4-channel TDM demultiplexer.
//
// Rebuilds four parallel channel words from a serial slot stream in which
// slot k carries channel k. Frame alignment comes from fsync, which marks
// slot 0. A complete frame is presented on y0..y3 together with a one-cycle
// frame_valid pulse, one cycle after the slot-3 beat is sampled.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   din          slot data, WIDTH bits
//   din_valid    din carries a slot this cycle
//   fsync        current beat is slot 0 (qualified by din_valid)
//   y0..y3       channel words of the last complete frame
//   frame_valid  one-cycle pulse, y0..y3 just updated
//   slot         index of the next expected slot
//   locked       1 while aligned (LOCKED state)
//   sync_err     one-cycle pulse on an alignment error
//   err_cnt      saturating sync_err counter (only with TDM_DEMUX_ERRCNT_EN)
//
// Optional build macro: TDM_DEMUX_ERRCNT_EN adds the err_cnt port/counter.

module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             slot_nxt;
  logic                   wr_en;
  logic [1:0]             wr_idx;
  logic                   done;
  logic                   err;
  logic [2:0][WIDTH-1:0]  shadow;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= 2'd0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_en     = 1'b0;
    wr_idx    = slot;
    done      = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (fsync) begin
            wr_en     = 1'b1;
            wr_idx    = 2'd0;
            slot_nxt  = 2'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == 2'd0) begin
            if (fsync) begin
              wr_en    = 1'b1;
              wr_idx   = 2'd0;
              slot_nxt = 2'd1;
            end else begin
              // missing marker: drop beat and realign from scratch
              err       = 1'b1;
              slot_nxt  = 2'd0;
              state_nxt = HUNT;
            end
          end else if (fsync) begin
            // early marker: abandon partial frame, beat starts a new one
            err      = 1'b1;
            wr_en    = 1'b1;
            wr_idx   = 2'd0;
            slot_nxt = 2'd1;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = slot;
            slot_nxt = slot + 2'd1;
            done     = (slot == 2'd3);
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow slots 0..2; slot 3 goes straight to y3 on completion, so a
  // partial frame is discarded simply by restarting the slot count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (wr_en && wr_idx != 2'd3) begin
      shadow[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= done;
      sync_err    <= err;
      if (done) begin
        y0 <= shadow[0];
        y1 <= shadow[1];
        y2 <= shadow[2];
        y3 <= din;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- randomized + directed bench for tdm_demux4 against a
// queue-based frame model. All outputs are compared after every edge.
module tb_tdm_demux4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       fsync;
  logic [7:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fsync(fsync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // reference model: a frame is a queue of words collected since slot 0
  bit         m_lock;
  logic [7:0] part[$];
  logic [7:0] my[4];
  bit         m_fv, m_err;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_lock = 0; part = {}; m_fv = 0; m_err = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) my[i] = 8'h00;
  endtask

  task automatic m_step(input bit v, input bit f, input logic [7:0] d);
    m_fv = 0; m_err = 0;
    if (!v) return;
    if (!m_lock) begin
      if (f) begin part = {d}; m_lock = 1; end
    end else if (part.size() == 0) begin
      if (f) part = {d};
      else begin m_err = 1; m_lock = 0; end
    end else if (f) begin
      m_err = 1; part = {d};
    end else begin
      part.push_back(d);
      if (part.size() == 4) begin
        for (int i = 0; i < 4; i++) my[i] = part[i];
        m_fv = 1; part = {};
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_all();
    chk("frame_valid", frame_valid, m_fv);
    chk("sync_err", sync_err, m_err);
    chk("locked", locked, m_lock);
    chk("slot", slot, part.size());
    chk("y0", y0, my[0]);
    chk("y1", y1, my[1]);
    chk("y2", y2, my[2]);
    chk("y3", y3, my[3]);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("err_cnt", err_cnt, m_cnt);
`endif
  endtask

  task automatic beat(input bit v, input bit f, input logic [7:0] d);
    @(negedge clk);
    din_valid = v; fsync = f; din = d;
    m_step(v, f, d);
    @(posedge clk);
    #1 check_all();
  endtask

  initial begin
    rst_n = 0; din = 0; din_valid = 0; fsync = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1;

    // reset then frame
    beat(1, 1, 8'hA5); beat(1, 0, 8'h3C); beat(1, 0, 8'h0F); beat(1, 0, 8'hF0);
    beat(0, 0, 8'h00);

    // hunt: fsync-less beats ignored after a fresh reset
    @(negedge clk) rst_n = 0; m_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1;
    beat(1, 0, 8'h11); beat(1, 0, 8'h22); beat(1, 0, 8'h33);
    beat(1, 1, 8'h01); beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);

    // early sync
    beat(1, 1, 8'h10); beat(1, 0, 8'h20); beat(1, 1, 8'h99);
    beat(1, 0, 8'h98); beat(1, 0, 8'h97); beat(1, 0, 8'h96);

    // missing sync
    beat(1, 0, 8'h55); beat(0, 0, 8'h00);

    // gap between slots 1 and 2
    beat(1, 1, 8'hC0); beat(1, 0, 8'hC1);
    repeat (3) beat(0, 0, 8'hEE);
    beat(1, 0, 8'hC2); beat(1, 0, 8'hC3);

    // back-to-back frames
    for (int fr = 0; fr < 4; fr++)
      for (int s = 0; s < 4; s++) beat(1, s == 0, 8'(fr * 16 + s + 1));

    // async reset mid-frame
    beat(1, 1, 8'h71); beat(1, 0, 8'h72);
    @(negedge clk);
    #1 rst_n = 0; m_reset();
    #1 check_all();
    #1 rst_n = 1;
    beat(1, 0, 8'h73); beat(1, 0, 8'h74); beat(1, 0, 8'h75); beat(1, 0, 8'h76);

    // repeated early syncs drive the error counter into saturation
    for (int i = 0; i < 300; i++) beat(1, 1, 8'(i));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit v, f;
      v = ($urandom % 4) != 0;
      f = (part.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 10) == 0);
      beat(v, f, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side 4-channel time-division demultiplexer.
- Takes a serial slot stream built by the 4:1 channel mux (slot k carries channel ik, k = {s1,s0}) and rebuilds the four parallel channel words.
- Tracks frame alignment using a frame-sync marker on slot 0.
- Presents a complete 4-word frame with a one-cycle valid pulse.

Parameters:
- WIDTH, 8, bit width of each channel word and of din.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  incoming slot data.
- din_valid  input  1  din holds a valid slot this cycle.
- fsync  input  1  marks the current din beat as slot 0. Only meaningful when din_valid=1.
- y0  output  WIDTH  channel 0 word (slot 0).
- y1  output  WIDTH  channel 1 word (slot 1).
- y2  output  WIDTH  channel 2 word (slot 2).
- y3  output  WIDTH  channel 3 word (slot 3).
- frame_valid  output  1  one-cycle pulse: y0..y3 updated with a new complete frame.
- slot  output  2  index of the next expected slot ({s1,s0} encoding).
- locked  output  1  1 when in LOCKED state.
- sync_err  output  1  one-cycle pulse on a detected alignment error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y0..y3=0, frame_valid=0, slot=0, locked=0, sync_err=0.
  - Shadow registers cleared; state=HUNT.
  - Reset mid-frame discards any partial frame.
- All state changes on rising clk. Cycles with din_valid=0 change nothing except clearing the one-cycle pulses.
- States: HUNT, LOCKED.
- HUNT:
  - Beats with fsync=0 are ignored.
  - A beat with din_valid=1 and fsync=1 is written to shadow slot 0; slot<=1; go LOCKED.
- LOCKED, beat with din_valid=1:
  - slot=0 and fsync=1: write shadow 0, slot<=1.
  - slot=0 and fsync=0: sync_err pulse; discard partial frame; slot<=0; go HUNT; the beat is dropped.
  - slot in 1..3 and fsync=0: write shadow[slot]; slot<=slot+1 (wraps 3->0).
  - slot in 1..3 and fsync=1 (early sync): sync_err pulse; discard partial frame; the beat is taken as slot 0 of a new frame (shadow 0 written, slot<=1); stay LOCKED.
- Frame completion:
  - Accepting slot 3 copies shadow 0..2 and the slot-3 beat into y0..y3 on the same edge, and sets frame_valid=1 for exactly the following cycle.
  - Latency: y/frame_valid visible 1 cycle after the slot-3 beat is sampled.
- y0..y3 hold their values between frames. A partial or aborted frame never modifies y0..y3.
- Back-to-back frames: with din_valid held at 1, frame_valid pulses every 4 cycles.
- Gaps: din_valid may drop anywhere mid-frame; the slot count pauses.
- sync_err and frame_valid never assert in the same cycle, since the error cases cannot complete a frame.
- locked mirrors the state register.

Optional Feature:
- Macro: TDM_DEMUX_ERRCNT_EN.
- When defined:
  - Adds output port err_cnt (8 bits), reset to 0.
  - Increments on every sync_err pulse and saturates at 255; no wrap.
  - Clears only on reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then frame: rst_n low 2 cycles; send A5(fsync),3C,0F,F0 with din_valid=1 -> next cycle frame_valid=1, y0=A5 y1=3C y2=0F y3=F0; locked=1.
- Hunt: before any fsync, send 11,22,33 with fsync=0 -> no frame_valid, locked=0, y* stay 0; then a full frame 01(fsync),02,03,04 -> y=01,02,03,04.
- Early sync: frame 10(fsync),20, then 99 with fsync=1, then 98,97,96 -> sync_err pulse on the 99 beat; next frame_valid gives y=99,98,97,96.
- Missing sync: after a valid frame, send 55 at slot 0 with fsync=0 -> sync_err=1, locked=0, y unchanged; with TDM_DEMUX_ERRCNT_EN, err_cnt=1.
- Gaps and back-to-back: frame with din_valid low 3 cycles between slots 1 and 2 -> correct y; 4 consecutive frames with din_valid held high -> frame_valid every 4th cycle.
- Async reset mid-frame: after slots 0,1 of a frame, pulse rst_n low between clock edges -> outputs 0 immediately; the remaining beats without fsync produce no frame.
